multicycle_ctrl: RTL

Multicycle sequencing controller for the RV32I core datapath: steps each instruction through fetch, decode, execute, memory and writeback. It drives the register-file, PC, IR, ALU-source and memory strobes around the immediate generator, ALU and unified memory port. It handles a single-beat memory ready handshake with a wait timeout, and traps on unsupported encodings.

---
 rtl/riscv_pkg.sv | 74 +++++++
 rtl/mem_wait_timer.sv | 52 +++++
 rtl/multicycle_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I encodings, controller state and instruction-class decode
//
// Purpose: constants and types shared by the multicycle controller and its helpers.
//   - opcode constants for the instruction classes the controller supports
//   - ctrl_state_t: controller FSM states
//   - pc_src / wb_sel / alu_op / trap_cause encodings
//   - classify(): maps opcode + funct3 onto a supported class or CL_ILLEGAL
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_R      = 7'b0110011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CL_R       = 3'd0,
        CL_IMM     = 3'd1,
        CL_LOAD    = 3'd2,
        CL_STORE   = 3'd3,
        CL_BRANCH  = 3'd4,
        CL_JALR    = 3'd5,
        CL_ILLEGAL = 3'd6
    } instr_class_t;

    // pc_src
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    // wb_sel
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // alu_op
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // trap_cause
    localparam logic [1:0] TC_NONE    = 2'd0;
    localparam logic [1:0] TC_ILLEGAL = 2'd1;
    localparam logic [1:0] TC_TIMEOUT = 2'd2;

    // Only BEQ/BNE are sequenced (single zero-flag compare), and JALR
    // must carry funct3 000; every other encoding is trapped.
    function automatic instr_class_t classify(input logic [6:0] opcode,
                                              input logic [2:0] funct3);
        instr_class_t cls;
        cls = CL_ILLEGAL;
        case (opcode)
            OP_R:      cls = CL_R;
            OP_IMM:    cls = CL_IMM;
            OP_LOAD:   cls = CL_LOAD;
            OP_STORE:  cls = CL_STORE;
            OP_BRANCH: cls = (funct3[2:1] == 2'b00) ? CL_BRANCH : CL_ILLEGAL;
            OP_JALR:   cls = (funct3 == 3'b000) ? CL_JALR : CL_ILLEGAL;
            default:   cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating memory wait counter with timeout compare
//
// Purpose: counts consecutive cycles a memory request has waited for ready.
// Ports:
//   clk     in  clock
//   reset   in  synchronous active-high reset
//   clear   in  restart the count (request state entered)
//   count   in  a request is waiting this cycle
//   ready   in  memory completes the request this cycle (also clears)
//   expired out the current waiting cycle is the last one allowed
module mem_wait_timer
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    input  logic ready,
    output logic expired
);

    localparam int unsigned CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned LIMIT_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LIMIT   = CW'(LIMIT_I);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || ready) begin
            cnt_d = '0;
        end else if (count && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A ready arriving on the limit cycle wins over the timeout.
    assign expired = (TIMEOUT_CYCLES != 0) && count && !ready && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I sequencing controller
//
// Purpose: steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives
// the datapath strobes as Mealy outputs of state, mem_ready and alu_zero.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   opcode, funct3             instruction fields (valid from DECODE onward)
//   alu_zero                   ALU result is zero
//   mem_ready                  memory completes the current request
//   mem_req, mem_we, addr_sel  memory request, store, address select
//   ir_write, pc_write, pc_src instruction latch and PC update
//   reg_write, wb_sel          register-file write and source
//   alu_src_b, alu_op          ALU operand B and operation
//   instr_done                 final cycle of an instruction
//   trap, trap_cause           sticky error and its cause
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);

    ctrl_state_t  state_q;
    ctrl_state_t  state_d;
    logic [1:0]   cause_q;
    logic [1:0]   cause_d;
    instr_class_t cls;
    logic         waiting;
    logic         tmr_clear;
    logic         tmr_expired;

    assign cls = classify(opcode, funct3);

    // The counter only runs while a memory request is outstanding.
    assign waiting   = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
    assign tmr_clear = reset ||
                       ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM)));

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .count  (waiting),
        .ready  (mem_ready),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        reg_write  = 1'b0;
        wb_sel     = WB_ALU;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        instr_done = 1'b0;
        trap       = 1'b0;
        trap_cause = TC_NONE;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TC_TIMEOUT;
                end
            end

            ST_DECODE: begin
                if (cls == CL_ILLEGAL) begin
                    state_d = ST_TRAP;
                    cause_d = TC_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                case (cls)
                    CL_R: begin
                        alu_op  = ALU_FUNCT;
                        state_d = ST_WB;
                    end
                    CL_IMM: begin
                        alu_src_b = 1'b1;
                        alu_op    = ALU_FUNCT;
                        state_d   = ST_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_src_b = 1'b1;
                        state_d   = ST_MEM;
                    end
                    CL_BRANCH: begin
                        // funct3[0] selects BNE: taken when the difference is non-zero.
                        alu_op     = ALU_SUB;
                        pc_write   = alu_zero ^ funct3[0];
                        pc_src     = PC_BRANCH;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    CL_JALR: begin
                        alu_src_b  = 1'b1;
                        reg_write  = 1'b1;
                        wb_sel     = WB_PC4;
                        pc_write   = 1'b1;
                        pc_src     = PC_ALU;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_FETCH;
                    end
                endcase
            end

            ST_MEM: begin
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = (cls == CL_STORE);
                alu_src_b = 1'b1;
                if (mem_ready) begin
                    if (cls == CL_STORE) begin
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TC_TIMEOUT;
                end
            end

            ST_WB: begin
                reg_write  = 1'b1;
                wb_sel     = (cls == CL_LOAD) ? WB_MEM : WB_ALU;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_q;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Reset silences every strobe, even mid-request.
        if (reset) begin
            state_d    = ST_FETCH;
            cause_d    = TC_NONE;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            addr_sel   = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = PC_PLUS4;
            reg_write  = 1'b0;
            wb_sel     = WB_ALU;
            alu_src_b  = 1'b0;
            alu_op     = ALU_ADD;
            instr_done = 1'b0;
            trap       = 1'b0;
            trap_cause = TC_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            cause_q <= TC_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

endmodule
